// File: rtl/sincos_nco_pkg.sv
// sincos_nco_pkg: shared constants, config-select encodings and helpers for the TDM NCO
package sincos_nco_pkg;
  localparam int PHASE_W = 32;
  localparam int CORE_LAT = 2;
  typedef enum logic [1:0] {CFG_FREQ = 2'd0, CFG_OFF = 2'd1, CFG_MODE = 2'd2} cfg_sel_e;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/nco_tag_fifo.sv
// nco_tag_fifo: synchronous show-ahead FIFO holding channel tags of samples inside the core
module nco_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic wr_en, rd_en;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // a push into a full FIFO is accepted only when the head leaves in the same cycle
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) mem[wr_ptr] <= din;
      if (wr_en) wr_ptr <= wr_ptr == AW'(DEPTH-1) ? '0 : wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr == AW'(DEPTH-1) ? '0 : rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
endmodule

// File: rtl/sincos_linear.sv
// sincos_linear: two-stage piecewise-linear sine/cosine of a 32-bit phase, signed full-scale output
module sincos_linear
  import sincos_nco_pkg::*;
#(
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [PHASE_W-1:0] phase,
  input  logic               mode_cos,
  input  logic               valid_i,
  output logic [W-1:0]       result,
  output logic               valid_o
);
  localparam logic [W-1:0] FS = {1'b0, {(W-1){1'b1}}};
  logic [PHASE_W-1:0] t;
  logic [30:0] x, x_r;
  logic neg_r, v_r;
  logic [W+30:0] prod;
  logic [W-1:0] mag;
  // cosine is sine advanced by a quarter turn; odd quadrants run the ramp backwards
  assign t = phase + (mode_cos ? 32'h4000_0000 : 32'h0);
  assign x = t[30] ? 31'h4000_0000 - {1'b0, t[29:0]} : {1'b0, t[29:0]};
  assign prod = (W+31)'(x_r) * (W+31)'(FS);
  assign mag = W'(prod >> 30);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      x_r <= '0;
      neg_r <= 1'b0;
      v_r <= 1'b0;
      result <= '0;
      valid_o <= 1'b0;
    end else begin
      x_r <= x;
      neg_r <= t[31];
      v_r <= valid_i;
      result <= neg_r ? -mag : mag;
      valid_o <= v_r;
    end
endmodule

// File: rtl/sincos_nco_tdm.sv
// sincos_nco_tdm: round-robin multi-channel NCO sharing one sincos_linear core, tagged results
module sincos_nco_tdm
  import sincos_nco_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int OUTPUT_WIDTH = 32,
  parameter int IN_REGS = 4,
  parameter int OUT_REGS = 4,
  parameter int TAG_DEPTH = 16,
  localparam int CW = ch_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable_i,
  input  logic                    sync_clr_i,
  input  logic                    cfg_we_i,
  input  logic [CW-1:0]           cfg_ch_i,
  input  logic [1:0]              cfg_sel_i,
  input  logic [31:0]             cfg_data_i,
  output logic [OUTPUT_WIDTH-1:0] result_o,
  output logic [CW-1:0]           ch_o,
  output logic                    valid_o,
  output logic                    ovf_o
);
  logic [PHASE_W-1:0] acc [NUM_CH];
  logic [PHASE_W-1:0] freq [NUM_CH];
  logic [PHASE_W-1:0] off [NUM_CH];
  logic [NUM_CH-1:0] mode;
  logic [CW-1:0] ch_ptr;
  logic [PHASE_W-1:0] in_ph [IN_REGS+1];
  logic in_m [IN_REGS+1];
  logic in_v [IN_REGS+1];
  logic [CW-1:0] in_c [IN_REGS+1];
  logic [OUTPUT_WIDTH-1:0] out_r [OUT_REGS+1];
  logic [CW-1:0] out_c [OUT_REGS+1];
  logic out_v [OUT_REGS+1];
  logic full, empty;
  // registers are read before update, so same-cycle writes only affect later issues
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
        freq[c] <= '0;
        off[c] <= '0;
      end
      mode <= '0;
      ch_ptr <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sync_clr_i) acc[c] <= '0;
        else if (enable_i && ch_ptr == CW'(c)) acc[c] <= acc[c] + freq[c];
        if (cfg_we_i && cfg_ch_i == CW'(c) && cfg_sel_i == CFG_FREQ) freq[c] <= cfg_data_i;
        if (cfg_we_i && cfg_ch_i == CW'(c) && cfg_sel_i == CFG_OFF) off[c] <= cfg_data_i;
        if (cfg_we_i && cfg_ch_i == CW'(c) && cfg_sel_i == CFG_MODE) mode[c] <= cfg_data_i[0];
      end
      ch_ptr <= sync_clr_i ? '0 : enable_i ? ch_ptr + CW'(1) : ch_ptr;
    end
  assign in_ph[0] = acc[ch_ptr] + off[ch_ptr];
  assign in_m[0] = mode[ch_ptr];
  assign in_c[0] = ch_ptr;
  assign in_v[0] = enable_i;
  for (genvar i = 0; i < IN_REGS; i++) begin : g_in
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        in_ph[i+1] <= '0;
        in_m[i+1] <= 1'b0;
        in_c[i+1] <= '0;
        in_v[i+1] <= 1'b0;
      end else begin
        in_ph[i+1] <= in_ph[i];
        in_m[i+1] <= in_m[i];
        in_c[i+1] <= in_c[i];
        in_v[i+1] <= in_v[i];
      end
  end
  sincos_linear #(.W(OUTPUT_WIDTH)) u_core (
    .clk(clk), .resetn(resetn), .phase(in_ph[IN_REGS]), .mode_cos(in_m[IN_REGS]),
    .valid_i(in_v[IN_REGS]), .result(out_r[0]), .valid_o(out_v[0])
  );
  nco_tag_fifo #(.WIDTH(CW), .DEPTH(TAG_DEPTH)) u_tags (
    .clk(clk), .resetn(resetn), .push(in_v[IN_REGS]), .pop(out_v[0]),
    .din(in_c[IN_REGS]), .dout(out_c[0]), .full(full), .empty(empty)
  );
  for (genvar i = 0; i < OUT_REGS; i++) begin : g_out
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        out_r[i+1] <= '0;
        out_c[i+1] <= '0;
        out_v[i+1] <= 1'b0;
      end else begin
        out_r[i+1] <= out_r[i];
        out_c[i+1] <= out_c[i];
        out_v[i+1] <= out_v[i];
      end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ovf_o <= 1'b0;
    else ovf_o <= ovf_o || (in_v[IN_REGS] && full && !out_v[0]) || (out_v[0] && empty);
  assign result_o = out_r[OUT_REGS];
  assign ch_o = out_c[OUT_REGS];
  assign valid_o = out_v[OUT_REGS];
endmodule
